// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: permutation tables, shift schedule, widths
// and the FSM state type used by the key schedule block.
package des_pkg;

    localparam int KEY_W  = 64;
    localparam int CD_W   = 56;
    localparam int SK_W   = 48;
    localparam int HALF_W = 28;
    localparam int ROUNDS = 16;

    // Table entries are 1-based FIPS bit numbers of the source vector.
    localparam int PC1 [CD_W] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [SK_W] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    localparam int SHIFT [ROUNDS] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    typedef enum logic {IDLE, RUN} state_e;

    typedef logic [0:HALF_W-1] half_t;

    // Barrel-shift control: bit 0 weighs 2, bit 1 weighs 1.
    function automatic logic [0:1] shift_code(input logic [3:0] idx);
        return 2'(SHIFT[idx]);
    endfunction

endpackage

// File: rtl/des_key_schedule_if.sv
// Load request and subkey stream between a key source/round engine (master)
// and the DES key schedule (slave).
interface des_key_schedule_if;
    import des_pkg::*;

    logic                start;
    logic                decrypt;
    logic [0:KEY_W-1]    key;
    logic                busy;
    logic                subkey_valid;
    logic                subkey_ready;
    logic [0:SK_W-1]     subkey;
    logic [3:0]          round;
    logic                done;

    modport master (
        output start, decrypt, key, subkey_ready,
        input  busy, subkey_valid, subkey, round, done
    );

    modport slave (
        input  start, decrypt, key, subkey_ready,
        output busy, subkey_valid, subkey, round, done
    );

endinterface

// File: rtl/barrel_shift.sv
// 28-bit left rotator: out[i] = in[(i + amt) mod 28], amt = 2*shift[0] + shift[1].
module barrel_shift (
    input  logic [0:27] data_i,
    input  logic [0:1]  shift,
    output logic [0:27] data_o
);
    logic [0:27] by_two;

    assign by_two = shift[0] ? {data_i[2:27], data_i[0:1]} : data_i;
    assign data_o = shift[1] ? {by_two[1:27], by_two[0]}   : by_two;

endmodule

// File: rtl/des_key_schedule.sv
// DES key schedule: loads PC-1(key) on start, then streams the sixteen round
// subkeys (K1..K16 encrypt, K16..K1 decrypt) one per valid/ready handshake.
module des_key_schedule
    import des_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    des_key_schedule_if.slave  ks
);
    state_e            state_q, state_d;
    half_t             c_q, c_d, d_q, d_d;
    logic [3:0]        round_q, round_d;
    logic              mode_q, mode_d;
    logic              done_q, done_d;

    logic [0:CD_W-1]   cd_load;
    logic [0:CD_W-1]   cd_sel;
    logic [0:SK_W-1]   subkey_pc2;
    half_t             c_rotl, d_rotl, c_rotr, d_rotr;
    logic [0:1]        shl_amt;
    logic              shr_two;
    logic              handshake;

    // The schedule only ever rotates by 1 or 2, so a two-way mux suffices.
    function automatic half_t rot_right(input half_t x, input logic two);
        return two ? {x[HALF_W-2:HALF_W-1], x[0:HALF_W-3]}
                   : {x[HALF_W-1], x[0:HALF_W-2]};
    endfunction

    for (genvar i = 0; i < CD_W; i++) begin : g_pc1
        assign cd_load[i] = ks.key[PC1[i] - 1];
    end

    assign shl_amt = shift_code(round_q);

    barrel_shift u_rotl_c (.data_i(c_q), .shift(shl_amt), .data_o(c_rotl));
    barrel_shift u_rotl_d (.data_i(d_q), .shift(shl_amt), .data_o(d_rotl));

    // Decrypt walks the encrypt schedule backwards, undoing S[15-round].
    assign shr_two = (SHIFT[4'd15 - round_q] == 2);
    assign c_rotr  = rot_right(c_q, shr_two);
    assign d_rotr  = rot_right(d_q, shr_two);

    // Encrypt presents the already-rotated halves; decrypt presents C,D as held.
    assign cd_sel = mode_q ? {c_q, d_q} : {c_rotl, d_rotl};

    for (genvar i = 0; i < SK_W; i++) begin : g_pc2
        assign subkey_pc2[i] = cd_sel[PC2[i] - 1];
    end

    assign handshake = (state_q == RUN) && ks.subkey_ready;

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        round_d = round_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ks.start) begin
                    state_d    = RUN;
                    {c_d, d_d} = cd_load;
                    round_d    = 4'd0;
                    mode_d     = ks.decrypt;
                end
            end
            RUN: begin
                if (handshake) begin
                    c_d     = mode_q ? c_rotr : c_rotl;
                    d_d     = mode_q ? d_rotr : d_rotl;
                    round_d = round_q + 4'd1;
                    if (round_q == 4'd15) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            c_q     <= '0;
            d_q     <= '0;
            round_q <= 4'd0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            round_q <= round_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    assign ks.busy         = (state_q == RUN);
    assign ks.subkey_valid = (state_q == RUN);
    assign ks.subkey       = subkey_pc2;
    assign ks.round        = round_q;
    assign ks.done         = done_q;

endmodule
